// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes, bubble encoding
// and reset vector, plus the branch-offset helper.
package if_stage_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'b00,
        PC_SRC_BR  = 2'b01,
        PC_SRC_J   = 2'b10,
        PC_SRC_JR  = 2'b11
    } pc_src_e;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Sign-extended word offset of an I-type branch, already scaled to bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_perf_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {WIDTH{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, ID-resolved
// branch/jump/jr redirect, and debug performance counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        data_hazard_stall,
    input  logic        control_hazard_stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] rs_data,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] cnt_cycle,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush
);

    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] redir_pc;

    assign imem_addr = pc;
    assign seq_pc    = pc + 32'd4;
    assign br_tgt    = id_pc4 + br_offset(id_inst[15:0]);
    assign j_tgt     = {id_pc4[31:28], id_inst[25:0], 2'b00};

    // A not-taken branch resumes at the slot that the redirect squashed.
    always_comb begin
        redir_pc = id_pc4;
        case (pc_src_e'(pc_src))
            PC_SRC_SEQ: redir_pc = id_pc4;
            PC_SRC_BR:  redir_pc = br_tgt;
            PC_SRC_J:   redir_pc = j_tgt;
            PC_SRC_JR:  redir_pc = rs_data;
            default:    redir_pc = id_pc4;
        endcase
    end

    // Data hazard outranks the redirect: branch operands may still be stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            id_inst  <= NOP_INST;
            id_pc4   <= 32'd0;
            id_valid <= 1'b0;
        end else if (cpu_en && !data_hazard_stall) begin
            if (control_hazard_stall) begin
                pc       <= redir_pc;
                id_inst  <= NOP_INST;
                id_pc4   <= 32'd0;
                id_valid <= 1'b0;
            end else begin
                pc       <= seq_pc;
                id_inst  <= imem_data;
                id_pc4   <= seq_pc;
                id_valid <= 1'b1;
            end
        end
    end

    logic stall_inc;
    logic flush_inc;

    assign stall_inc = cpu_en && data_hazard_stall;
    assign flush_inc = cpu_en && !data_hazard_stall && control_hazard_stall;

    perf_counter #(.WIDTH(32)) u_cnt_cycle (
        .clk (clk),
        .rst (rst),
        .inc (cpu_en),
        .cnt (cnt_cycle)
    );

    perf_counter #(.WIDTH(32)) u_cnt_stall (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (cnt_stall)
    );

    perf_counter #(.WIDTH(32)) u_cnt_flush (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (cnt_flush)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; a narrow perf_counter instance exercises saturation.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, cpu_en, dstall, cstall;
    logic [1:0]  pc_src;
    logic [31:0] rs_data, imem_addr, imem_data, id_inst, id_pc4;
    logic        id_valid;
    logic [31:0] cnt_cycle, cnt_stall, cnt_flush;
    logic        ovr_en;
    logic [31:0] ovr_inst;
    logic        sat_inc;
    logic [1:0]  sat_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0, stl = 0, fl = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_data = ovr_en ? ovr_inst : rom(imem_addr);

    if_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .cpu_en               (cpu_en),
        .data_hazard_stall    (dstall),
        .control_hazard_stall (cstall),
        .pc_src               (pc_src),
        .rs_data              (rs_data),
        .imem_addr            (imem_addr),
        .imem_data            (imem_data),
        .id_inst              (id_inst),
        .id_pc4               (id_pc4),
        .id_valid             (id_valid),
        .cnt_cycle            (cnt_cycle),
        .cnt_stall            (cnt_stall),
        .cnt_flush            (cnt_flush)
    );

    perf_counter #(.WIDTH(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .inc (sat_inc),
        .cnt (sat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge while tracking the expected counter values.
    task automatic step();
        if (rst) begin
            cyc = 0; stl = 0; fl = 0;
        end else if (cpu_en) begin
            cyc++;
            if (dstall) stl++;
            else if (cstall) fl++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".cyc"},   cnt_cycle, cyc);
        chk({tag, ".stall"}, cnt_stall, stl);
        chk({tag, ".flush"}, cnt_flush, fl);
    endtask

    task automatic fetch(input logic [31:0] inst);
        ovr_en = 1'b1; ovr_inst = inst;
        step();
        ovr_en = 1'b0;
    endtask

    task automatic redirect(input logic [1:0] src, input logic [31:0] rs);
        cstall = 1'b1; pc_src = src; rs_data = rs;
        step();
        cstall = 1'b0; pc_src = 2'b00;
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b1; dstall = 1'b0; cstall = 1'b0;
        pc_src = 2'b00; rs_data = 32'd0; ovr_en = 1'b0; ovr_inst = 32'd0;
        sat_inc = 1'b0;
        @(negedge clk);
        step(); step();
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.inst", id_inst, 32'h0);
        chk("rst.valid", {31'd0, id_valid}, 32'd0);
        chk("rst.pc4", id_pc4, 32'h0);
        chk_cnt("rst");

        rst = 1'b0; sat_inc = 1'b1;
        step(); step();
        chk("sat.two", {30'd0, sat_cnt}, 32'd2);
        step();
        chk("run.addr", imem_addr, 32'd12);
        chk("run.pc4", id_pc4, 32'd12);
        chk("run.inst", id_inst, 32'hA5A5_0008);
        chk("run.valid", {31'd0, id_valid}, 32'd1);
        chk("sat.top", {30'd0, sat_cnt}, 32'd3);
        step(); step();
        chk("sat.hold", {30'd0, sat_cnt}, 32'd3);
        sat_inc = 1'b0;
        step(); step(); step();
        chk("run.addr20", imem_addr, 32'h20);
        chk_cnt("run");

        dstall = 1'b1;
        step(); step();
        dstall = 1'b0;
        chk("dstall.addr", imem_addr, 32'h20);
        chk("dstall.inst", id_inst, 32'hA5A5_001C);
        chk("dstall.cnt", cnt_stall, 32'd2);
        step();
        chk("dstall.resume", imem_addr, 32'h24);
        chk("dstall.inst2", id_inst, 32'hA5A5_0020);

        repeat (6) step();
        fetch(32'h1000_0003);
        chk("beq.pc4", id_pc4, 32'h40);
        chk("beq.inst", id_inst, 32'h1000_0003);
        redirect(2'b01, 32'd0);
        chk("beq.addr", imem_addr, 32'h4C);
        chk("beq.valid", {31'd0, id_valid}, 32'd0);
        chk("beq.inst_nop", id_inst, 32'h0);
        chk("beq.flush", cnt_flush, 32'd1);

        redirect(2'b11, 32'h88);
        chk("jr.addr", imem_addr, 32'h88);
        redirect(2'b11, 32'h1000_0000);
        fetch(32'h0C10_0000);
        chk("jal.pc4", id_pc4, 32'h1000_0004);
        redirect(2'b10, 32'd0);
        chk("jal.addr", imem_addr, 32'h1040_0000);

        redirect(2'b11, 32'h5C);
        fetch(32'h1400_FFFF);
        chk("bne.pc4", id_pc4, 32'h60);
        redirect(2'b00, 32'd0);
        chk("bne.addr", imem_addr, 32'h60);
        chk("bne.valid", {31'd0, id_valid}, 32'd0);
        chk_cnt("bne");

        step();
        dstall = 1'b1; cstall = 1'b1; pc_src = 2'b10;
        step(); step();
        dstall = 1'b0; cstall = 1'b0; pc_src = 2'b00;
        chk("prio.addr", imem_addr, 32'h64);
        chk("prio.inst", id_inst, 32'hA5A5_0060);
        chk("prio.pc4", id_pc4, 32'h64);
        chk("prio.flush", cnt_flush, 32'd6);
        chk_cnt("prio");

        redirect(2'b11, 32'hFFFF_FFFC);
        step();
        chk("wrap.addr", imem_addr, 32'h0);
        chk("wrap.pc4", id_pc4, 32'h0);
        chk("wrap.inst", id_inst, rom(32'hFFFF_FFFC));

        cpu_en = 1'b0; dstall = 1'b1; cstall = 1'b1; pc_src = 2'b11; rs_data = 32'h88;
        repeat (5) step();
        chk("en.addr", imem_addr, 32'h0);
        chk("en.inst", id_inst, rom(32'hFFFF_FFFC));
        chk("en.valid", {31'd0, id_valid}, 32'd1);
        chk_cnt("en");

        cpu_en = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; cstall = 1'b0; dstall = 1'b0; pc_src = 2'b00;
        chk("rstmid.addr", imem_addr, 32'h0);
        chk("rstmid.valid", {31'd0, id_valid}, 32'd0);
        chk_cnt("rstmid");
        step();
        chk("rstmid.next", imem_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
